// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer: round-robin or software-selected grant,
// with a single valid/ready output register that sustains one word per cycle.
module stream_mux_rr #(
    parameter int SIZE      = 16,
    parameter int CHANNELS  = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS*SIZE-1:0] in_data,
    input  logic [CHANNELS-1:0]      in_valid,
    output logic [CHANNELS-1:0]      in_ready,
    input  logic                     mode,
    input  logic [SEL_WIDTH-1:0]     switch,
    output logic [SIZE-1:0]          out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_WIDTH-1:0]     out_sel
);

    localparam int                   PAD_W = 2 ** (SEL_WIDTH + 1);
    localparam logic [SEL_WIDTH:0]   CH_N  = (SEL_WIDTH + 1)'(CHANNELS);
    localparam logic [SEL_WIDTH-1:0] LAST  = SEL_WIDTH'(CHANNELS - 1);

    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SIZE-1:0]      data_p0;
    logic [SEL_WIDTH-1:0] sel_p0;
    logic                 vld_p0;

    logic [PAD_W-1:0]     valid_pad;
    logic                 load_en;
    logic                 grant_valid;
    logic                 accept;
    logic [SEL_WIDTH-1:0] grant;
    logic [SEL_WIDTH:0]   idx;
    logic [SIZE-1:0]      grant_data;

    // Zero-padded so any (SEL_WIDTH+1)-bit index is in range; unused channels read as idle.
    assign valid_pad = PAD_W'(in_valid);
    assign load_en   = !vld_p0 || out_ready;
    assign accept    = !rst && load_en && grant_valid;

    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = '0;
        if (mode) begin
            if (({1'b0, switch} < CH_N) && valid_pad[{1'b0, switch}]) begin
                grant_valid = 1'b1;
                grant       = switch;
            end
        end else begin
            // Scan from the farthest offset down so the nearest requester after rr_ptr wins.
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                idx = {1'b0, rr_ptr} + (SEL_WIDTH + 1)'(k);
                if (idx >= CH_N) idx = idx - CH_N;
                if (valid_pad[idx]) begin
                    grant_valid = 1'b1;
                    grant       = idx[SEL_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_WIDTH'(i)) begin
                in_ready[i] = accept;
                grant_data  = in_data[i*SIZE +: SIZE];
            end
        end
    end

    // Stage p0: output register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            sel_p0  <= '0;
            rr_ptr  <= '0;
        end else if (load_en) begin
            if (grant_valid) begin
                vld_p0  <= 1'b1;
                data_p0 <= grant_data;
                sel_p0  <= grant;
                if (!mode) rr_ptr <= (grant == LAST) ? '0 : grant + 1'b1;
            end else begin
                vld_p0 <= 1'b0;
            end
        end
    end

    assign out_data  = data_p0;
    assign out_sel   = sel_p0;
    assign out_valid = vld_p0;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance share stimulus and are
// compared every cycle against a queue-free transaction-level model of the grant rules.
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic        mode;
    logic [1:0]  switch;
    logic        out_ready;

    logic [3:0]  rdy4;
    logic [15:0] od4;
    logic        ov4;
    logic [1:0]  os4;
    logic [2:0]  rdy3;
    logic [15:0] od3;
    logic        ov3;
    logic [1:0]  os3;

    stream_mux_rr #(.SIZE(16), .CHANNELS(4), .SEL_WIDTH(2)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy4),
        .mode(mode), .switch(switch), .out_data(od4), .out_valid(ov4),
        .out_ready(out_ready), .out_sel(os4)
    );

    stream_mux_rr #(.SIZE(16), .CHANNELS(3), .SEL_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data[47:0]), .in_valid(in_valid[2:0]), .in_ready(rdy3),
        .mode(mode), .switch(switch), .out_data(od3), .out_valid(ov3),
        .out_ready(out_ready), .out_sel(os3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state per instance: index 0 = 4 channels, index 1 = 3 channels.
    bit          mv[2];
    logic [15:0] md[2];
    int          ms[2];
    int          mp[2];
    bit          gv[2];
    int          g[2];
    bit          ld[2];

    function automatic int nch(input int m);
        return (m == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; md[m] = 16'h0; ms[m] = 0; mp[m] = 0;
        end
    endtask

    task automatic predict();
        for (int m = 0; m < 2; m++) begin
            int n;
            n     = nch(m);
            gv[m] = 1'b0;
            g[m]  = 0;
            ld[m] = !mv[m] || out_ready;
            if (mode) begin
                if (int'(switch) < n && in_valid[switch]) begin
                    gv[m] = 1'b1;
                    g[m]  = int'(switch);
                end
            end else begin
                for (int off = 0; off < n; off++) begin
                    int c;
                    c = (mp[m] + off) % n;
                    if (!gv[m] && in_valid[c]) begin
                        gv[m] = 1'b1;
                        g[m]  = c;
                    end
                end
            end
        end
    endtask

    task automatic check_ready();
        logic [31:0] exp;
        predict();
        for (int m = 0; m < 2; m++) begin
            exp = (!rst && ld[m] && gv[m]) ? (32'd1 << g[m]) : 32'd0;
            chk($sformatf("in_ready_ch%0d", nch(m)), (m == 0) ? 32'(rdy4) : 32'(rdy3), exp);
        end
    endtask

    task automatic advance();
        for (int m = 0; m < 2; m++) begin
            if (ld[m]) begin
                if (gv[m]) begin
                    mv[m] = 1'b1;
                    md[m] = in_data[g[m]*16 +: 16];
                    ms[m] = g[m];
                    if (!mode) mp[m] = (g[m] + 1) % nch(m);
                end else begin
                    mv[m] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_out();
        chk("out_valid_ch4", 32'(ov4), 32'(mv[0]));
        chk("out_data_ch4",  32'(od4), 32'(md[0]));
        chk("out_sel_ch4",   32'(os4), ms[0]);
        chk("out_valid_ch3", 32'(ov3), 32'(mv[1]));
        chk("out_data_ch3",  32'(od3), 32'(md[1]));
        chk("out_sel_ch3",   32'(os3), ms[1]);
    endtask

    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        #1 check_ready();
        @(posedge clk);
        advance();
        #1 check_out();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        check_ready();
        check_out();
        @(posedge clk);
        #1 check_ready();
        check_out();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_pattern_data();
        for (int i = 0; i < 4; i++) in_data[i*16 +: 16] = 16'hA000 + 16'(i);
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; switch = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_ready();
        check_out();

        // Load a word, stall it, then reset asynchronously mid-transfer
        rst = 1'b0;
        set_pattern_data();
        in_valid = 4'hF;
        cycle();
        cycle();
        async_reset();

        // Rotation with back-to-back transfers; first grant after reset must be channel 0
        out_ready = 1'b1;
        cycle();
        chk("first_after_rst", 32'(os4), 32'd0);
        repeat (5) cycle();

        // Skip and wrap: park pointer after channel 2, then only channels 1 and 3 request
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b1010;
        repeat (3) cycle();

        // Backpressure for 5 cycles, then drain and reload from channel 2 on the same edge
        in_valid = 4'hF;
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = {$urandom, $urandom};
            in_valid = 4'($urandom);
            cycle();
        end
        out_ready = 1'b1;
        in_valid = 4'b0100;
        cycle();

        // Fixed select, missing requester, out-of-range select on the 3-channel instance
        mode = 1'b1; switch = 2'd2; in_valid = 4'hF;
        repeat (4) cycle();
        in_valid = 4'b1011;
        repeat (2) cycle();
        switch = 2'd3; in_valid = 4'hF;
        repeat (2) cycle();
        mode = 1'b0;
        repeat (3) cycle();

        // Mode toggling every cycle under full load
        for (int i = 0; i < 24; i++) begin
            mode = ~mode;
            switch = 2'($urandom);
            in_data = {$urandom, $urandom};
            cycle();
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_data   = {$urandom, $urandom};
            in_valid  = 4'($urandom);
            mode      = ($urandom_range(0, 3) == 0);
            switch    = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        async_reset();
        in_valid = 4'hF; mode = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel registered multiplexer with valid/ready handshaking. It is the next generation of the team's combinational 4:1 selector. It either arbitrates fairly (round-robin) among requesting channels or forwards one software-selected channel, and registers the winner into a single output stage. It sits between multiple producers (register-file write sources, memory/ALU result paths) and a single consumer that may stall.

## Interface
- SIZE, 16, data width per channel in bits
- CHANNELS, 4, number of input channels, 2 to 16
- SEL_WIDTH, 2, width of the select/index fields; CHANNELS <= 2**SEL_WIDTH
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  CHANNELS*SIZE  packed inputs; channel i occupies bits [i*SIZE +: SIZE]
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept (combinational), at most one bit high
- mode  input  1  0 = round-robin arbitration, 1 = fixed select via switch
- switch  input  SEL_WIDTH  channel index used when mode = 1
- out_data  output  SIZE  registered selected data
- out_valid  output  1  out_data/out_sel hold a pending word
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_sel  output  SEL_WIDTH  index of the channel that produced out_data

## Operation
- State: output register (out_data, out_sel, out_valid) and round-robin pointer rr_ptr (SEL_WIDTH bits).
- load_en = !out_valid || out_ready. The output stage can take a new word whenever it is empty or is being drained this cycle.
- Grant, mode 0: grant goes to the first channel i with in_valid[i], scanning rr_ptr, rr_ptr+1, …, CHANNELS-1, 0, …, rr_ptr-1. Wrap is modulo CHANNELS, not 2**SEL_WIDTH.
- Grant, mode 1: grant = switch if switch < CHANNELS and in_valid[switch]. Otherwise there is no grant. Other channels are never granted.
- in_ready[i] = !rst && load_en && grant valid && grant == i.
- Accept (any in_ready[i] && in_valid[i]):
  - out_data <= channel i data
  - out_sel <= i
  - out_valid <= 1
- On accept in mode 0: rr_ptr <= (i == CHANNELS-1) ? 0 : i+1.
- On accept in mode 1: rr_ptr is unchanged.
- load_en with no grant: out_valid <= 0. out_data and out_sel hold their last values.
- !load_en (out_valid && !out_ready): all output state holds and every in_ready is 0.
- mode and switch are sampled combinationally each cycle. Changing them never corrupts a word already in the output register.
- Reset (async assert): out_valid=0, out_data=0, out_sel=0, rr_ptr=0. in_ready is all 0 while rst is high. Any word pending at reset is discarded.

## Timing
- Latency: a word accepted at edge k appears on out_data with out_valid=1 after edge k, i.e. one cycle.
- Throughput: one word per cycle when out_ready is held high. No bubble is inserted on back-to-back transfers, because load_en includes out_ready.
- in_ready depends combinationally on in_valid, mode, switch, out_ready and state. It has no combinational path from in_data.
- Simultaneous drain and load: out_valid stays 1 and the new word replaces the old one at the same edge.
- Fairness: in mode 0 with all channels continuously valid, grants rotate 0,1,…,CHANNELS-1,0. A continuously valid channel waits at most CHANNELS-1 accepts.
- Reset deassertion: first accept is possible on the first edge after rst falls. Scanning starts at channel 0.

## Test plan
- Reset mid-transfer: load a word, assert rst asynchronously between edges -> out_valid=0, out_data=0, out_sel=0 immediately, in_ready=0 for the duration of rst; after release, all channels valid -> channel 0 granted first.
- Round-robin rotation, CHANNELS=4, SIZE=16: channel i drives 16'hA000+i, all valid, out_ready=1 -> out_sel sequence 0,1,2,3,0, out_data A000..A003,A000, one word per cycle.
- Skip and wrap: rr_ptr=3, only channels 1 and 3 valid -> grant 3 then 1, then 3 again. Repeat with CHANNELS=3 (SEL_WIDTH=2) -> pointer wraps from 2 to 0, never reaches 3.
- Backpressure: out_ready=0 with out_valid=1 for 5 cycles -> out_data and out_sel stable, all in_ready=0. Raise out_ready with channel 2 valid -> drain and reload on the same edge, out_valid stays 1.
- Fixed mode: mode=1, switch=2, channels 0-3 all valid -> only in_ready[2] is ever high and rr_ptr is unchanged. switch=2 with in_valid[2]=0 -> no accept, out_valid falls after drain. CHANNELS=3, switch=3 -> no grant.
- Mode switch under load: alternate mode every cycle with all channels valid -> every accepted word's out_sel matches the grant rule of the mode active in its accept cycle, and no word is lost or duplicated (scoreboard).
